// File: rtl/spi_reg_master_pkg.sv
// Shared encodings for the SPI register master: transaction width codes,
// header bit positions and small helpers to build the outgoing frame.
package spi_reg_master_pkg;

  typedef enum logic [1:0] {
    WID_8   = 2'b00,
    WID_16  = 2'b01,
    WID_32  = 2'b10,
    WID_32X = 2'b11
  } width_e;

  localparam int HDR_BITS     = 16;
  localparam int HDR_RW_BIT   = 15;
  localparam int HDR_WID_LSB  = 6;
  localparam int HDR_ADDR_LSB = 0;

  function automatic logic [5:0] data_bits(input logic [1:0] w);
    case (w)
      WID_8:   data_bits = 6'd8;
      WID_16:  data_bits = 6'd16;
      default: data_bits = 6'd32;
    endcase
  endfunction

  function automatic logic [15:0] make_header(input logic rw, input logic [1:0] w,
                                              input logic [5:0] addr);
    logic [15:0] h;
    h = '0;
    h[HDR_RW_BIT] = rw;
    h[HDR_WID_LSB +: 2] = w;
    h[HDR_ADDR_LSB +: 6] = addr;
    return h;
  endfunction

  // Left-align the used data bits so the frame shifts out MSB first from bit 31.
  function automatic logic [31:0] align_wdata(input logic [31:0] wdata, input logic [1:0] w);
    case (w)
      WID_8:   align_wdata = {wdata[7:0], 24'b0};
      WID_16:  align_wdata = {wdata[15:0], 16'b0};
      default: align_wdata = wdata;
    endcase
  endfunction

endpackage

// File: rtl/spi_reg_master_sync.sv
// Multi-flop synchronizer for signals arriving asynchronously to clk.
module spi_reg_master_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES*WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[(STAGES-1)*WIDTH-1:0], d};
  end

  assign q = chain[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 register master: 16-bit header then 8/16/32 data bits.
// Optional ready timeout enabled by defining SPI_REG_MASTER_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for start, enforcing cs-high gap
// CS_SETUP   | cs low, sclk low for CLK_DIV cycles
// HDR        | shifting 16 header bits
// WAIT_RDY   | read only: sclk low until synchronized slv_ready
// DATA       | shifting N data bits (out on write, in on read)
// CS_HOLD    | sclk low for CLK_DIV cycles, then cs high
// DONE       | one-cycle done pulse
module spi_reg_master
  import spi_reg_master_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rw,
  input  logic [1:0]  txn_width,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  input  logic        slv_ready
);

  if (CLK_DIV < 2 || CLK_DIV > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_reg_master: illegal CLK_DIV or TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_HDR, S_WAIT_RDY, S_DATA, S_CS_HOLD, S_DONE
  } state_e;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  state_e      state;
  logic [7:0]  div_cnt;
  logic [7:0]  gap_cnt;
  logic [4:0]  bit_cnt;
  logic [47:0] tx_sr;
  logic [31:0] rx_sr;
  logic        rw_q;
  logic [1:0]  wid_q;
  logic        rdy_sync;

`ifdef SPI_REG_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             aborted;
  logic             err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  spi_reg_master_sync #(.STAGES(2), .WIDTH(1)) u_rdy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (slv_ready),
    .q     (rdy_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      spi_cs_n <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rw_q     <= 1'b0;
      wid_q    <= '0;
`ifdef SPI_REG_MASTER_TIMEOUT_EN
      tmo_cnt  <= '0;
      aborted  <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      // gap_cnt holds cs high after a frame; cs may only fall once it reaches zero
      if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            rw_q     <= rw;
            wid_q    <= txn_width;
            tx_sr    <= {make_header(rw, txn_width, addr), align_wdata(wdata, txn_width)};
            rx_sr    <= '0;
            spi_mosi <= rw;
            div_cnt  <= DIV_LOAD;
            state    <= S_CS_SETUP;
`ifdef SPI_REG_MASTER_TIMEOUT_EN
            aborted  <= 1'b0;
`endif
            if (gap_cnt == 8'd0) spi_cs_n <= 1'b0;
          end
        end
        S_CS_SETUP: begin
          if (spi_cs_n) begin
            if (gap_cnt == 8'd0) spi_cs_n <= 1'b0;
          end else if (div_cnt == 8'd0) begin
            spi_clk <= 1'b1;
            bit_cnt <= 5'(HDR_BITS - 1);
            div_cnt <= DIV_LOAD;
            state   <= S_HDR;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        S_HDR, S_DATA: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_LOAD;
            if (spi_clk) begin
              spi_clk  <= 1'b0;
              tx_sr    <= tx_sr << 1;
              spi_mosi <= tx_sr[46];
              if (state == S_DATA && bit_cnt == 5'd0) state <= S_CS_HOLD;
            end else if (bit_cnt != 5'd0) begin
              spi_clk <= 1'b1;
              bit_cnt <= bit_cnt - 5'd1;
              if (state == S_DATA) rx_sr <= {rx_sr[30:0], spi_miso};
            end else if (rw_q) begin
              spi_clk <= 1'b1;
              bit_cnt <= 5'(data_bits(wid_q) - 6'd1);
              state   <= S_DATA;
            end else begin
              state <= S_WAIT_RDY;
`ifdef SPI_REG_MASTER_TIMEOUT_EN
              tmo_cnt <= TMO_LOAD;
`endif
            end
          end
        end
        S_WAIT_RDY: begin
          if (rdy_sync) begin
            spi_clk <= 1'b1;
            bit_cnt <= 5'(data_bits(wid_q) - 6'd1);
            div_cnt <= DIV_LOAD;
            rx_sr   <= {rx_sr[30:0], spi_miso};
            state   <= S_DATA;
          end
`ifdef SPI_REG_MASTER_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            aborted <= 1'b1;
            div_cnt <= DIV_LOAD;
            state   <= S_CS_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
`endif
        end
        S_CS_HOLD: begin
          if (div_cnt == 8'd0) begin
            spi_cs_n <= 1'b1;
            done     <= 1'b1;
            gap_cnt  <= DIV_LOAD;
            state    <= S_DONE;
`ifdef SPI_REG_MASTER_TIMEOUT_EN
            err_q <= aborted;
            if (!rw_q && !aborted) rdata <= rx_sr;
`else
            if (!rw_q) rdata <= rx_sr;
`endif
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
`ifdef SPI_REG_MASTER_TIMEOUT_EN
          err_q <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
